// File: rtl/ldst_pkg.sv
// rtl/ldst_pkg.sv - load/store unit encodings and byte-enable constants
package ldst_pkg;

  localparam logic [2:0] LDST_LB  = 3'b000;
  localparam logic [2:0] LDST_LH  = 3'b001;
  localparam logic [2:0] LDST_LW  = 3'b010;
  localparam logic [2:0] LDST_LBU = 3'b011;
  localparam logic [2:0] LDST_LHU = 3'b100;
  localparam logic [2:0] LDST_SB  = 3'b101;
  localparam logic [2:0] LDST_SH  = 3'b110;
  localparam logic [2:0] LDST_SW  = 3'b111;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

  function automatic logic is_store(input logic [2:0] ctrl);
    return ctrl >= LDST_SB;
  endfunction

endpackage

// File: rtl/ldst_align.sv
// rtl/ldst_align.sv - byte-lane steering: store lane mask/replication or load extraction/extension
module ldst_align
  import ldst_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [3:0]  be,
  output logic        misalign
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = data_in[7:0];
      2'd1:    byte_v = data_in[15:8];
      2'd2:    byte_v = data_in[23:16];
      default: byte_v = data_in[31:24];
    endcase
    half_v = addr_lo[1] ? data_in[31:16] : data_in[15:0];

    data_out = 32'h0;
    be       = 4'b0000;
    misalign = 1'b0;
    case (ctrl)
      LDST_LB:  data_out = {{24{byte_v[7]}}, byte_v};
      LDST_LBU: data_out = {24'h0, byte_v};
      LDST_LH: begin
        data_out = {{16{half_v[15]}}, half_v};
        misalign = addr_lo[0];
      end
      LDST_LHU: begin
        data_out = {16'h0, half_v};
        misalign = addr_lo[0];
      end
      LDST_LW: begin
        data_out = data_in;
        misalign = |addr_lo;
      end
      LDST_SB: begin
        data_out = {4{data_in[7:0]}};
        be       = BE_B << addr_lo;
      end
      LDST_SH: begin
        data_out = {2{data_in[15:0]}};
        be       = BE_H << addr_lo;
        misalign = addr_lo[0];
      end
      default: begin
        data_out = data_in;
        be       = BE_W;
        misalign = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/ld_st_unit.sv
// rtl/ld_st_unit.sv - single-outstanding load/store stage over a valid/ready data-memory port
module ld_st_unit
  import ldst_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  ldst_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        st_done,
  output logic        misalign_err,
  output logic        bus_err
);

  state_e      state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] addr_q, addr_d;
  logic [4:0]  rd_q, rd_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        st_done_q, st_done_d;
  logic        mis_q, mis_d;
  logic        bus_err_q, bus_err_d;

  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_be, unused_ld_be;
  logic        st_mis, unused_ld_mis;
  logic        timeout;

  // Store-side instance works on the incoming request so lanes are registered at accept.
  ldst_align u_st_align (
    .ctrl     (ldst_ctrl),
    .addr_lo  (addr[1:0]),
    .data_in  (store_data),
    .data_out (st_wdata),
    .be       (st_be),
    .misalign (st_mis)
  );

  ldst_align u_ld_align (
    .ctrl     (ctrl_q),
    .addr_lo  (addr_q[1:0]),
    .data_in  (dmem_rdata),
    .data_out (ld_data),
    .be       (unused_ld_be),
    .misalign (unused_ld_mis)
  );

  assign timeout = ({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT);

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    st_done_d  = 1'b0;
    mis_d      = 1'b0;
    bus_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (st_mis) begin
            mis_d = 1'b1;
          end else begin
            state_d = REQ;
            ctrl_d  = ldst_ctrl;
            addr_d  = addr;
            rd_d    = rd;
            we_d    = st_be;
            wdata_d = is_store(ldst_ctrl) ? st_wdata : 32'h0;
            cnt_d   = 8'd0;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (timeout) begin
          state_d   = IDLE;
          bus_err_d = 1'b1;
          we_d      = 4'b0000;
        end else if (dmem_req_ready) begin
          we_d = 4'b0000;
          if (is_store(ctrl_q)) begin
            state_d   = IDLE;
            st_done_d = 1'b1;
          end else begin
            state_d = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt_q + 8'd1;
        if (timeout) begin
          state_d   = IDLE;
          bus_err_d = 1'b1;
        end else if (dmem_rsp_valid) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_data_d  = ld_data;
          wb_rd_d    = rd_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ctrl_q     <= 3'b000;
      addr_q     <= 32'h0;
      rd_q       <= 5'd0;
      we_q       <= 4'b0000;
      wdata_q    <= 32'h0;
      cnt_q      <= 8'd0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'h0;
      wb_rd_q    <= 5'd0;
      st_done_q  <= 1'b0;
      mis_q      <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      st_done_q  <= st_done_d;
      mis_q      <= mis_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign dmem_req_valid = (state_q == REQ);
  assign dmem_addr      = {addr_q[31:2], 2'b00};
  assign dmem_we        = we_q;
  assign dmem_wdata     = wdata_q;
  assign wb_valid       = wb_valid_q;
  assign wb_data        = wb_data_q;
  assign wb_rd          = wb_rd_q;
  assign st_done        = st_done_q;
  assign misalign_err   = mis_q;
  assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_ld_st_unit.sv
// tb/tb_ld_st_unit.sv - directed vector table plus timeout, reset and back-to-back sequences
module tb_ld_st_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  ldst_ctrl;
  logic [31:0] addr, store_data;
  logic [4:0]  rd;
  logic        busy, dmem_req_valid, dmem_req_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_we;
  logic        dmem_rsp_valid;
  logic        wb_valid, st_done, misalign_err, bus_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  int n_tests = 0;
  int n_fail  = 0;

  ld_st_unit #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .ldst_ctrl(ldst_ctrl), .addr(addr), .store_data(store_data), .rd(rd),
    .busy(busy),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .st_done(st_done), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        mis;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] wb;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    req_valid = 1'b1; ldst_ctrl = v.ctrl; addr = v.addr; store_data = v.sdata; rd = v.rd;
    dmem_rdata = v.rdata; dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1;
    chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    if (v.mis) begin
      chk($sformatf("v%0d misalign_err", i), 32'(misalign_err), 32'd1);
      chk($sformatf("v%0d no dmem_req", i), 32'(dmem_req_valid), 32'd0);
      chk($sformatf("v%0d ready stays", i), 32'(req_ready), 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d misalign pulse", i), 32'(misalign_err), 32'd0);
      chk($sformatf("v%0d no dmem_req2", i), 32'(dmem_req_valid), 32'd0);
    end else begin
      chk($sformatf("v%0d dmem_req_valid", i), 32'(dmem_req_valid), 32'd1);
      chk($sformatf("v%0d dmem_addr", i), dmem_addr, v.addr & 32'hFFFF_FFFC);
      chk($sformatf("v%0d dmem_we", i), 32'(dmem_we), 32'(v.we));
      if (v.ctrl >= 3'b101) begin
        chk($sformatf("v%0d dmem_wdata", i), dmem_wdata, v.wdata);
        @(negedge clk);
        chk($sformatf("v%0d st_done", i), 32'(st_done), 32'd1);
        chk($sformatf("v%0d st busy", i), 32'(busy), 32'd0);
      end else begin
        @(negedge clk);
        chk($sformatf("v%0d wb early", i), 32'(wb_valid), 32'd0);
        chk($sformatf("v%0d wait busy", i), 32'(busy), 32'd1);
        @(negedge clk);
        chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'd1);
        chk($sformatf("v%0d wb_data", i), wb_data, v.wb);
        chk($sformatf("v%0d wb_rd", i), 32'(wb_rd), 32'(v.rd));
      end
    end
  endtask

  initial begin
    int  n_req;
    bit  seen_err, seen_wb;

    //           ctrl    addr          sdata         rdata         rd  mis we       wdata         wb
    vecs[0]  = '{3'b011, 32'h0000_1003, 32'h0,        32'h80FF_1122, 5'd5, 1'b0, 4'b0000, 32'h0, 32'h0000_0080};
    vecs[1]  = '{3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1122, 5'd6, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FF80};
    vecs[2]  = '{3'b001, 32'h0000_1002, 32'h0,        32'h80FF_1122, 5'd7, 1'b0, 4'b0000, 32'h0, 32'hFFFF_80FF};
    vecs[3]  = '{3'b100, 32'h0000_1002, 32'h0,        32'h80FF_1122, 5'd8, 1'b0, 4'b0000, 32'h0, 32'h0000_80FF};
    vecs[4]  = '{3'b010, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 5'd9, 1'b0, 4'b0000, 32'h0, 32'hDEAD_BEEF};
    vecs[5]  = '{3'b000, 32'h0000_1001, 32'h0,        32'h80FF_1122, 5'd10, 1'b0, 4'b0000, 32'h0, 32'h0000_0011};
    vecs[6]  = '{3'b001, 32'h0000_1000, 32'h0,        32'h80FF_9122, 5'd11, 1'b0, 4'b0000, 32'h0, 32'hFFFF_9122};
    vecs[7]  = '{3'b101, 32'h0000_2001, 32'h0000_00AB, 32'h0,        5'd0, 1'b0, 4'b0010, 32'hABAB_ABAB, 32'h0};
    vecs[8]  = '{3'b110, 32'h0000_2002, 32'h1234_CDEF, 32'h0,        5'd0, 1'b0, 4'b1100, 32'hCDEF_CDEF, 32'h0};
    vecs[9]  = '{3'b111, 32'h0000_2008, 32'hCAFE_F00D, 32'h0,        5'd0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[10] = '{3'b101, 32'h0000_2003, 32'h0000_0C5A, 32'h0,        5'd0, 1'b0, 4'b1000, 32'h5A5A_5A5A, 32'h0};
    vecs[11] = '{3'b010, 32'h0000_3002, 32'h0,        32'h0,        5'd1, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[12] = '{3'b110, 32'h0000_2003, 32'h0,        32'h0,        5'd0, 1'b1, 4'b0000, 32'h0, 32'h0};

    rst_n = 1'b0; req_valid = 1'b0; ldst_ctrl = 3'b0; addr = 32'h0; store_data = 32'h0;
    rd = 5'd0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset dmem_req_valid", 32'(dmem_req_valid), 32'd0);
    chk("reset dmem_we", 32'(dmem_we), 32'd0);
    chk("reset pulses", {28'd0, wb_valid, st_done, misalign_err, bus_err}, 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(i);

    // Timeout: memory never accepts the request.
    @(negedge clk);
    req_valid = 1'b1; ldst_ctrl = 3'b010; addr = 32'h0000_4000; rd = 5'd3;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    n_req = 0; seen_err = 1'b0; seen_wb = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (wb_valid) seen_wb = 1'b1;
      if (bus_err) begin
        seen_err = 1'b1;
        break;
      end
      if (dmem_req_valid) n_req++;
    end
    chk("timeout bus_err seen", 32'(seen_err), 32'd1);
    chk("timeout REQ cycles", 32'(n_req), 32'd8);
    chk("timeout busy", 32'(busy), 32'd0);
    chk("timeout dmem_req_valid", 32'(dmem_req_valid), 32'd0);
    chk("timeout no wb", 32'(seen_wb), 32'd0);
    @(negedge clk);
    chk("timeout bus_err pulse", 32'(bus_err), 32'd0);

    // Reset while waiting for a response, then a late response.
    req_valid = 1'b1; ldst_ctrl = 3'b010; addr = 32'h0000_5000; rd = 5'd4;
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst wait busy", 32'(busy), 32'd1);
    chk("rst wait no req", 32'(dmem_req_valid), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst mid busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    dmem_rsp_valid = 1'b1;
    seen_wb = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (wb_valid) seen_wb = 1'b1;
    end
    chk("rst late rsp no wb", 32'(seen_wb), 32'd0);
    chk("rst ready", 32'(req_ready), 32'd1);
    dmem_rsp_valid = 1'b0;

    // Back-to-back loads with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; ldst_ctrl = 3'b010; addr = 32'h0000_1000; rd = 5'd7;
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1; dmem_rdata = 32'h80FF_1122;
    @(negedge clk);
    ldst_ctrl = 3'b011; addr = 32'h0000_1003; rd = 5'd9;
    chk("b2b first in REQ", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("b2b wb1 valid", 32'(wb_valid), 32'd1);
    chk("b2b wb1 rd", 32'(wb_rd), 32'd7);
    chk("b2b wb1 data", wb_data, 32'h80FF_1122);
    chk("b2b ready in wb cycle", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b second accepted", 32'(dmem_req_valid), 32'd1);
    chk("b2b wb pulse", 32'(wb_valid), 32'd0);
    chk("b2b wb_data hold", wb_data, 32'h80FF_1122);
    @(negedge clk);
    @(negedge clk);
    chk("b2b wb2 valid", 32'(wb_valid), 32'd1);
    chk("b2b wb2 rd", 32'(wb_rd), 32'd9);
    chk("b2b wb2 data", wb_data, 32'h0000_0080);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
